// File: rtl/sw_conditioner_pkg.sv
// Shared definitions for the push-button conditioner and the BMP180 sequencer
// that consumes its command strobes.
package sw_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 20000;
  localparam int ACK_TIMEOUT_DEFAULT     = 16;
  localparam int N_SW_DEFAULT            = 7;

  // Button bit positions within sw_raw / sw_pulse
  localparam int SW_ID       = 0;
  localparam int SW_SETTINGS = 1;
  localparam int SW_TEMP     = 2;
  localparam int SW_GTEMP    = 3;
  localparam int SW_PRESS    = 4;
  localparam int SW_GPRESS   = 5;
  localparam int SW_SHOW     = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_FIRE,
    ST_ACK
  } sw_state_e;

  // Counter width that can hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle press event on each released->pressed transition.
module sw_debounce_ch
  import sw_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw_i,
  output logic press_o
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          press_q, press_d;
  logic          pressed;

  // Buttons are active-low; a 1 out of the synchronizer means released.
  assign pressed = ~sync2_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (pressed != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so the synchronizer stages shift rather than collapse.
      sync1_q <= sw_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sw_conditioner.sv
// Debounces the front-panel buttons, arbitrates simultaneous presses and hands
// one command strobe at a time to the BMP180 sequencer, pacing on its ready flag.
module sw_conditioner
  import sw_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  input  logic            ready,
  output logic [N_SW-1:0] sw_pulse,
  output logic            pending,
  output logic            dropped
);

  localparam int            TW       = cnt_width(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] ACK_MAX  = TW'(ACK_TIMEOUT);

  logic [N_SW-1:0] press;
  logic [N_SW-1:0] press_lsb;
  logic            press_multi;

  logic [N_SW-1:0] evt_q;
  logic            evt_drop_q;

  sw_state_e       state_q, state_d;
  logic [N_SW-1:0] cmd_q,   cmd_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            seen_low_q, seen_low_d;
  logic            fsm_drop;

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    sw_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .sw_raw_i (sw_raw[g]),
      .press_o  (press[g])
    );
  end

  // Lowest index wins; x & -x isolates the least significant set bit.
  assign press_lsb   = press & (~press + N_SW'(1));
  assign press_multi = |(press & ~press_lsb);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    timer_d    = timer_q;
    seen_low_d = seen_low_q;
    sw_pulse   = '0;
    pending    = 1'b0;
    fsm_drop   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|evt_q) begin
          cmd_d   = evt_q;
          state_d = ready ? ST_FIRE : ST_PEND;
        end
      end
      ST_PEND: begin
        pending  = 1'b1;
        fsm_drop = |evt_q;
        if (ready) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        sw_pulse   = cmd_q;
        fsm_drop   = |evt_q;
        state_d    = ST_ACK;
        timer_d    = '0;
        seen_low_d = 1'b0;
      end
      ST_ACK: begin
        fsm_drop = |evt_q;
        if (!ready) seen_low_d = 1'b1;
        if (timer_q < ACK_MAX) timer_d = timer_q + 1'b1;
        // Leave on a completed busy/idle handshake, or give up when the
        // controller never went busy (commands that start no bus transfer).
        if (ready && (seen_low_q || timer_q == ACK_LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q      <= '0;
      evt_drop_q <= 1'b0;
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      timer_q    <= '0;
      seen_low_q <= 1'b0;
    end else begin
      evt_q      <= press_lsb;
      evt_drop_q <= press_multi;
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      timer_q    <= timer_d;
      seen_low_q <= seen_low_d;
    end
  end

  assign dropped = evt_drop_q | fsm_drop;

endmodule

// File: tb/tb_sw_conditioner.sv
// Self-checking bench: directed scenarios plus random button/ready traffic,
// compared every cycle against a behavioural model of the conditioner.
module tb_sw_conditioner;

  localparam int D  = 8;
  localparam int N  = 7;
  localparam int AT = 16;

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_FIRE = 2;
  localparam int PH_ACK  = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         ready;
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_pulse;
  logic         pending;
  logic         dropped;

  always #5 clk = ~clk;

  sw_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .N_SW           (N),
    .ACK_TIMEOUT    (AT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .ready    (ready),
    .sw_pulse (sw_pulse),
    .pending  (pending),
    .dropped  (dropped)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: raw sample history, debounced levels, event pipeline, controller
  logic [N-1:0] hist[$];
  logic [N-1:0] m_db, m_press, m_evt, m_cmd;
  logic         m_multi;
  int           phase, ack_age;
  bit           ack_low;
  logic [N-1:0] e_pulse;
  logic         e_pending, e_dropped;

  int           cyc = 0;
  int           pulse_cnt, drop_cnt, first_pulse_cyc;
  logic [N-1:0] last_pulse, prev_pulse;

  function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return N'(1) << i;
    return '0;
  endfunction

  task automatic model_outputs();
    e_pulse   = (phase == PH_FIRE) ? m_cmd : '0;
    e_pending = (phase == PH_WAIT);
    e_dropped = m_multi || ((m_evt != '0) && (phase != PH_IDLE));
  endtask

  task automatic model_reset();
    hist.delete();
    m_db    = '0;
    m_press = '0;
    m_evt   = '0;
    m_cmd   = '0;
    m_multi = 1'b0;
    phase   = PH_IDLE;
    ack_age = 0;
    ack_low = 0;
    model_outputs();
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic [N-1:0] up;
    int           s;
    bit           all_same;
    up = '0;
    s  = hist.size();
    // A level flips once the last D synchronized raw samples all sat at the
    // opposite logical level (raw==db means the button reads opposite to db).
    for (int ch = 0; ch < N; ch++) begin
      if (s >= D + 1) begin
        all_same = 1;
        for (int j = 1; j <= D; j++)
          if (hist[s-1-j][ch] != m_db[ch]) all_same = 0;
        if (all_same) begin
          m_db[ch] = ~m_db[ch];
          up[ch]   = m_db[ch];
        end
      end
    end
    hist.push_back(sw_raw);
    if (hist.size() > D + 1) void'(hist.pop_front());

    case (phase)
      PH_IDLE: if (m_evt != '0) begin
        m_cmd = m_evt;
        phase = ready ? PH_FIRE : PH_WAIT;
      end
      PH_WAIT: if (ready) phase = PH_FIRE;
      PH_FIRE: begin
        phase   = PH_ACK;
        ack_age = 0;
        ack_low = 0;
      end
      default: begin
        if (ready && ack_low) phase = PH_IDLE;
        else if (ready && !ack_low && ack_age == AT - 1) phase = PH_IDLE;
        if (!ready) ack_low = 1;
        ack_age++;
      end
    endcase

    m_multi = ($countones(m_press) > 1);
    m_evt   = lowest(m_press);
    m_press = up;
    model_outputs();
  endtask

  task automatic clear_stats();
    pulse_cnt       = 0;
    drop_cnt        = 0;
    first_pulse_cyc = -1;
    last_pulse      = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("sw_pulse", 32'(sw_pulse), 32'(e_pulse));
    check("pending",  32'(pending),  32'(e_pending));
    check("dropped",  32'(dropped),  32'(e_dropped));
    check("pulse_onehot", 32'($countones(sw_pulse) <= 1), 32'(1));
    check("pulse_gap", 32'((|sw_pulse) && (|prev_pulse)), 32'(0));
    if (|sw_pulse) begin
      pulse_cnt++;
      last_pulse = sw_pulse;
      if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
    end
    if (dropped) drop_cnt++;
    prev_pulse = sw_pulse;
  endtask

  // Called at a falling edge; asserts reset mid-cycle and checks outputs clear at once.
  task automatic do_reset(input int hold);
    #2 reset = 1'b1;
    #1;
    check("rst_pulse",   32'(sw_pulse), 32'(0));
    check("rst_pending", 32'(pending),  32'(0));
    check("rst_dropped", 32'(dropped),  32'(0));
    model_reset();
    prev_pulse = '0;
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic settle();
    sw_raw = '1;
    ready  = 1'b1;
    repeat (40) tick();
  endtask

  task automatic ack_boundary(input int gap);
    clear_stats();
    sw_raw[6] = 1'b0;
    repeat (gap) tick();
    sw_raw[5] = 1'b0;
    repeat (20) tick();
    sw_raw = '1;
    repeat (40) tick();
  endtask

  initial begin
    int t0;
    int hold[N];
    int rhold;

    reset      = 1'b1;
    sw_raw     = '1;
    ready      = 1'b1;
    prev_pulse = '0;
    model_reset();
    clear_stats();
    repeat (3) @(negedge clk);
    check("reset_pulse",   32'(sw_pulse), 32'(0));
    check("reset_pending", 32'(pending),  32'(0));
    check("reset_dropped", 32'(dropped),  32'(0));
    reset = 1'b0;
    settle();

    // Clean press of swTemp
    clear_stats();
    sw_raw[2] = 1'b0;
    t0 = cyc + 1;
    repeat (20) tick();
    sw_raw = '1;
    repeat (30) tick();
    check("clean_count",   32'(pulse_cnt), 32'(1));
    check("clean_value",   32'(last_pulse), 32'(7'b0000100));
    check("clean_latency", 32'(first_pulse_cyc - t0), 32'(11));
    check("clean_drop",    32'(drop_cnt), 32'(0));

    // Bounce rejection on swId
    clear_stats();
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw_raw[0] = ~sw_raw[0];
      tick();
    end
    check("bounce_quiet", 32'(pulse_cnt), 32'(0));
    sw_raw[0] = 1'b0;
    t0 = cyc + 1;
    repeat (20) tick();
    check("bounce_count",   32'(pulse_cnt), 32'(1));
    check("bounce_value",   32'(last_pulse), 32'(1));
    check("bounce_latency", 32'(first_pulse_cyc - t0), 32'(11));
    settle();

    // Pending while the controller is busy
    clear_stats();
    ready     = 1'b0;
    sw_raw[3] = 1'b0;
    repeat (20) tick();
    check("pend_flag",  32'(pending), 32'(1));
    check("pend_quiet", 32'(pulse_cnt), 32'(0));
    sw_raw = '1;
    repeat (30) tick();
    ready = 1'b1;
    tick();
    check("pend_fire",  32'(sw_pulse), 32'(7'b0001000));
    check("pend_clear", 32'(pending), 32'(0));
    settle();

    // Simultaneous presses: lowest index wins
    clear_stats();
    sw_raw[1] = 1'b0;
    sw_raw[4] = 1'b0;
    repeat (20) tick();
    sw_raw = '1;
    repeat (30) tick();
    check("prio_count", 32'(pulse_cnt), 32'(1));
    check("prio_value", 32'(last_pulse), 32'(7'b0000010));
    check("prio_drop",  32'(drop_cnt), 32'(1));
    settle();

    // ACK timeout: second event on the first IDLE cycle is taken, one cycle earlier is dropped
    ack_boundary(18);
    check("ack_accept_count", 32'(pulse_cnt), 32'(2));
    check("ack_accept_drop",  32'(drop_cnt), 32'(0));
    check("ack_accept_value", 32'(last_pulse), 32'(7'b0100000));
    ack_boundary(17);
    check("ack_late_count", 32'(pulse_cnt), 32'(1));
    check("ack_late_drop",  32'(drop_cnt), 32'(1));
    settle();

    // Reset during PEND discards the command
    clear_stats();
    ready     = 1'b0;
    sw_raw[3] = 1'b0;
    repeat (15) tick();
    check("rstpend_flag", 32'(pending), 32'(1));
    sw_raw = '1;
    do_reset(2);
    ready = 1'b1;
    repeat (30) tick();
    check("rstpend_nopulse", 32'(pulse_cnt), 32'(0));

    // Button held through reset release is debounced afresh
    clear_stats();
    sw_raw[2] = 1'b0;
    do_reset(2);
    repeat (20) tick();
    check("held_count", 32'(pulse_cnt), 32'(1));
    check("held_value", 32'(last_pulse), 32'(7'b0000100));
    settle();

    // Random traffic
    for (int ch = 0; ch < N; ch++) hold[ch] = 0;
    rhold = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (hold[ch] == 0) begin
          sw_raw[ch] = ($urandom_range(0, 9) < 6);
          hold[ch]   = $urandom_range(1, 3 * D);
        end else begin
          hold[ch]--;
        end
      end
      if (rhold == 0) begin
        ready = ($urandom_range(0, 3) != 0);
        rhold = $urandom_range(1, 24);
      end else begin
        rhold--;
      end
      if ($urandom_range(0, 599) == 0) do_reset(1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_conditioner.md
SW_CONDITIONER -- requirements
Module: sw_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20000, giving the stable-input time in clk cycles (20 ms at 1 MHz).
REQ-002 The block SHALL have parameter N_SW, default 7, giving the number of button channels.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 16, giving the maximum cycles to wait for ready to fall after a command pulse.
REQ-004 clk  input  1  divided 1 MHz system clock; single clock domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sw_raw  input  N_SW  raw active-low buttons. Bit map: 0 swId, 1 swSettings, 2 swTemp, 3 swGTemp, 4 swPress, 5 swGPress, 6 swShow.
REQ-007 ready  input  1  I2C controller idle flag; 1 means a new command can be accepted.
REQ-008 sw_pulse  output  N_SW  one-hot, single-cycle command strobes to the BMP180 sequencer.
REQ-009 pending  output  1  high while a debounced press is latched but not yet issued.
REQ-010 dropped  output  1  single-cycle strobe when a press is discarded.

Function
REQ-011 Each sw_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL keep a debounced level, reset to 0 (released), and a counter.
- When the synchronized (inverted) input differs from the debounced level, the counter increments.
- The counter clears whenever the input equals the debounced level.
REQ-013 A channel SHALL toggle its debounced level when its counter reaches DEBOUNCE_CYCLES-1 with the input still differing; the counter then clears.
REQ-014 A press event SHALL be one cycle, generated on each 0->1 transition of a debounced level; releases SHALL generate no event.
REQ-015 Simultaneous press events SHALL be resolved by priority, lowest index wins; the losing events SHALL be discarded with one dropped strobe.
REQ-016 The control FSM SHALL have four states: IDLE, PEND, FIRE and ACK.
REQ-017 IDLE transitions:
- On a press event, latch its one-hot index.
- If ready=1, go to FIRE; otherwise go to PEND.
REQ-018 PEND SHALL assert pending and stay until ready=1, then go to FIRE; any new press event in PEND SHALL be discarded with dropped.
REQ-019 FIRE SHALL last exactly one cycle.
- sw_pulse equals the latched index during FIRE.
- FIRE goes to ACK.
- Press events in FIRE are discarded with dropped.
REQ-020 ACK transitions:
- Return to IDLE when ready=0 is seen, then ready=1.
- Also return to IDLE after ACK_TIMEOUT cycles if ready never falls (e.g. swShow, which starts no bus transfer).
- Press events in ACK are discarded with dropped.
REQ-021 Latency from the first stable synchronized sample to sw_pulse SHALL be 2 sync + DEBOUNCE_CYCLES + 1 cycles when ready=1 throughout.
REQ-022 sw_pulse SHALL have at most one bit set in any cycle, and never in two consecutive cycles.
REQ-023 Counter width SHALL be clog2(DEBOUNCE_CYCLES); ACK timer width SHALL be clog2(ACK_TIMEOUT+1). Both saturate and never wrap.

Reset
REQ-024 Asserting reset SHALL immediately force the following, regardless of clk:
- synchronizers to released;
- debounced levels, counters and ACK timer to 0;
- FSM to IDLE;
- sw_pulse=0, pending=0, dropped=0.
REQ-025 A button held through reset release SHALL be debounced afresh and produce one press event.
REQ-026 A reset asserted during PEND or ACK SHALL discard the latched command; no pulse issues after release.

Structure
REQ-027 A shared package SHALL hold the following, for the BMP180 sequencer to reuse:
- the FSM state enumeration;
- the bit-index constants SW_ID..SW_SHOW;
- the default DEBOUNCE_CYCLES and ACK_TIMEOUT values.
REQ-028 One sub-module, sw_debounce_ch (synchronizer, counter, debounced level, press event), SHALL be instantiated N_SW times by generate; the arbiter and FSM live in the top.

Verification
REQ-029 Scenario, clean press: DEBOUNCE_CYCLES=8, ready=1, sw_raw[2] low for 20 cycles -> exactly one sw_pulse=7'b0000100, 11 cycles after the first low sample; no dropped.
REQ-030 Scenario, bounce rejection: sw_raw[0] toggled every 3 cycles for 40 cycles, then held low -> no pulse during bouncing; one pulse of bit 0 after 8 stable cycles.
REQ-031 Scenario, pending: ready=0, press bit 3 -> pending=1 and no pulse; ready rises 50 cycles later -> sw_pulse=7'b0001000 the next cycle, pending=0.
REQ-032 Scenario, priority: bits 1 and 4 pressed on the same cycle -> sw_pulse bit 1 only; one dropped strobe.
REQ-033 Scenario, ACK timeout: press bit 6 with ready held 1 -> pulse, then ACK for 16 cycles, then IDLE; a second press is then accepted normally.
REQ-034 Scenario, reset mid-operation: assert reset during PEND -> outputs are 0 within the same cycle; ready=1 after release -> no pulse.
